// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with substitute-payload select and synchronous flush.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer whose handshake outputs come straight from flops.
module pipe_stage_reg #(
    parameter int                DATA_W  = 71,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              sub_i,
    input  logic [DATA_W-1:0] sub_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);
    logic [DATA_W-1:0] in_payload;
    logic              accept;
    logic              retire;
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;

    assign in_payload  = sub_i ? sub_data_i : in_data_i;
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign retire      = main_valid_q && out_ready_i;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [1:0]        occ_q, occ_d;
    logic              main_from_skid, main_from_in, skid_from_in;

    // Flush must not let the skid entry slide into main: payload registers stay untouched.
    always_comb begin
        main_from_skid = retire && skid_valid_q && !flush_i;
        main_from_in   = accept && !skid_valid_q && (!main_valid_q || retire);
        skid_from_in   = accept && !main_from_in;
        main_valid_d   = flush_i ? 1'b0 : (main_from_skid || main_from_in) ? 1'b1 : retire ? 1'b0 : main_valid_q;
        skid_valid_d   = flush_i ? 1'b0 : skid_from_in ? 1'b1 : main_from_skid ? 1'b0 : skid_valid_q;
        main_data_d    = main_from_skid ? skid_data_q : main_from_in ? in_payload : main_data_q;
        skid_data_d    = skid_from_in ? in_payload : skid_data_q;
        occ_d          = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    assign in_ready_o  = !skid_valid_q;
    assign occupancy_o = occ_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= RST_VAL;
            occ_q        <= 2'd0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            occ_q        <= occ_d;
        end
    end
`else
    always_comb begin
        main_valid_d = flush_i ? 1'b0 : accept ? 1'b1 : retire ? 1'b0 : main_valid_q;
        main_data_d  = accept ? in_payload : main_data_q;
    end

    assign in_ready_o  = out_ready_i || !main_valid_q;
    assign occupancy_o = {1'b0, main_valid_q};
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RST_VAL;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against a queue-based reference.
module tb_pipe_stage_reg;
    localparam int W = 71;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         sub = 1'b0;
    logic [W-1:0] sub_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occ;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] q[$];

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .sub_i(sub), .sub_data_i(sub_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .occupancy_o(occ)
    );

    function automatic logic m_ready();
        return (DEPTH == 2) ? (q.size() < 2) : (out_ready || q.size() == 0);
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Advance one clock edge and apply the stage's transfer rules to the reference queue.
    task automatic tick();
        logic acc, ret;
        logic [W-1:0] p;
        acc = in_valid && m_ready() && !flush;
        ret = q.size() > 0 && out_ready;
        p   = sub ? sub_data : in_data;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (ret) void'(q.pop_front());
            if (acc) q.push_back(p);
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; sub = 1'b0; flush = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic fill();
        idle_inputs();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = rnd();
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        n_tests++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", in_ready); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = W'(1);
        tick();
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b1 || out_data !== W'(1)) begin
            n_fail++; $display("FAIL first_accept got v=%0b d=%h want v=1 d=1", out_valid, out_data);
        end
        tick();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_data !== W'(i) || q.size() != 1 || q[0] !== W'(i)) begin
                n_fail++; $display("FAIL b2b_%0d got v=%0b d=%h want v=1 d=%0d", i, out_valid, out_data, i);
            end
        end
        drain();
    endtask

    task automatic test_skid();
        logic [W-1:0] got[$];
        idle_inputs();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = W'('hA);
        tick();
        in_data = W'('hB);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (occ !== 2'(DEPTH) || in_ready !== 1'b0 || out_data !== W'('hA) || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL skid_hold_%0d got occ=%0d rdy=%0b d=%h want occ=%0d rdy=0 d=a", i, occ, in_ready, out_data, DEPTH);
            end
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10 && got.size() < 2; c++) begin
            logic taken;
            #1;
            taken = in_valid && m_ready();
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
            if (taken) in_valid = 1'b0;
        end
        n_tests++; if (got.size() != 2 || got[0] !== W'('hA) || got[1] !== W'('hB)) begin
            n_fail++; $display("FAIL skid_order got %0d items want a then b", got.size());
        end
        drain();
    endtask

    task automatic test_sub();
        logic [1:0] occ_before;
        idle_inputs();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = W'(5); sub = 1'b1; sub_data = W'(7);
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_data !== W'(7)) begin
            n_fail++; $display("FAIL sub_select got v=%0b d=%h want v=1 d=7", out_valid, out_data);
        end
        out_ready = 1'b0;
        sub = 1'b1; sub_data = W'('h99);
        #1;
        occ_before = occ;
        tick();
        n_tests++; if (occ !== occ_before || occ !== 2'(q.size()) || out_data !== W'(7)) begin
            n_fail++; $display("FAIL sub_no_accept got occ=%0d d=%h want occ=%0d d=7", occ, out_data, occ_before);
        end
        drain();
    endtask

    task automatic test_flush();
        fill();
        #1;
        n_tests++; if (occ !== 2'(DEPTH)) begin n_fail++; $display("FAIL flush_prefill got %0d want %0d", occ, DEPTH); end
        flush = 1'b1; in_valid = 1'b1; in_data = W'('hF1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_clear got v=%0b occ=%0d rdy=%0b want 0 0 1", out_valid, occ, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak_%0d got v=1 d=%h want v=0", i, out_data); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            sub = ($urandom % 4) == 0;
            flush = ($urandom % 25) == 0;
            in_data = rnd(); sub_data = rnd();
            #1;
            n_tests++;
            if (out_valid !== (q.size() > 0) || occ !== 2'(q.size()) || in_ready !== m_ready() ||
                (q.size() > 0 && out_data !== q[0])) begin
                n_fail++;
                $display("FAIL random_%0d got v=%0b occ=%0d rdy=%0b d=%h want occ=%0d rdy=%0b d=%h",
                         c, out_valid, occ, in_ready, out_data, q.size(), m_ready(), (q.size() > 0) ? q[0] : '0);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_async_reset();
        fill();
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1 || out_data !== '0) begin
            n_fail++; $display("FAIL async_reset got v=%0b occ=%0d rdy=%0b d=%h want 0 0 1 0", out_valid, occ, in_ready, out_data);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = W'(3);
        tick();
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_data !== W'(3) || occ !== 2'd1) begin
            n_fail++; $display("FAIL after_reset_accept got v=%0b d=%h occ=%0d want 1 3 1", out_valid, out_data, occ);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_skid();
        test_sub();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 71, payload width in bits (ALU 32 + data 32 + RD 5 + MemtoReg 1 + RegWrite 1).
REQ-002 SHALL have parameter RST_VAL, default 0, reset value of every payload register, DATA_W bits.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_i  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid_i  input  1  upstream has a payload.
REQ-007 SHALL have port in_ready_o  output  1  stage accepts a payload this cycle.
REQ-008 SHALL have port in_data_i  input  DATA_W  normal upstream payload.
REQ-009 SHALL have port sub_i  input  1  substitute select; replaces MemStall-style override.
REQ-010 SHALL have port sub_data_i  input  DATA_W  substitute payload.
REQ-011 SHALL have port out_valid_o  output  1  downstream payload valid.
REQ-012 SHALL have port out_ready_i  input  1  downstream consumes payload.
REQ-013 SHALL have port out_data_o  output  DATA_W  registered payload to downstream.
REQ-014 SHALL have port occupancy_o  output  2  entries held, 0..2.

Function
REQ-015 SHALL accept a payload on a rising edge where in_valid_i && in_ready_o && !flush_i.
REQ-016 SHALL capture sub_data_i when sub_i=1 at the accept edge, else in_data_i; sub_i without accept has no effect.
REQ-017 SHALL present an accepted payload on out_data_o with out_valid_o=1 exactly one cycle after the accept edge when the stage was empty.
REQ-018 SHALL retire the output entry on a rising edge where out_valid_o && out_ready_i.
REQ-019 SHALL hold out_data_o and out_valid_o stable while out_valid_o=1 and out_ready_i=0.
REQ-020 SHALL preserve order: payloads leave in acceptance order, none lost, none duplicated.
REQ-021 SHALL drive out_valid_o, in_ready_o and occupancy_o only from registers when PIPE_STAGE_SKID_EN is defined.
REQ-022 SHALL, with skid: main (output) register plus one skid register; in_ready_o = !skid_valid.
REQ-023 SHALL, with skid, on accept: write main if main empty or retiring this edge and skid empty; otherwise write skid.
REQ-024 SHALL, with skid, on retire with skid full: move skid to main same edge; a simultaneous accept then fills skid.
REQ-025 SHALL sustain one transfer per cycle when out_ready_i=1 continuously.
REQ-026 SHALL give flush_i priority over accept and retire: next edge clears all valid bits, occupancy_o=0, input that cycle discarded.
REQ-027 SHALL leave payload data registers unchanged on flush; only valid state clears.
REQ-028 SHALL report occupancy_o = main_valid + skid_valid.

Reset
REQ-029 SHALL on rst_i=0, immediately and independent of clk_i: out_valid_o=0, skid_valid=0, occupancy_o=0, out_data_o=RST_VAL, skid data=RST_VAL.
REQ-030 SHALL drive in_ready_o=1 during and after reset.
REQ-031 SHALL discard any in-flight payload when reset asserts mid-operation; first accept after release enters the main register.

Configuration
REQ-032 SHALL, with macro PIPE_STAGE_SKID_EN defined, implement the two-entry skid behaviour of REQ-021..REQ-025.
REQ-033 SHALL, without PIPE_STAGE_SKID_EN, implement one entry only: in_ready_o = out_ready_i || !out_valid_o (combinational), no skid register, occupancy_o in 0..1, REQ-026/027 unchanged.

Verification
REQ-034 SHALL cover: reset, then accept 0x1 with out_ready_i=1 continuously -> out_valid_o=1 with out_data_o=0x1 next cycle; back-to-back 0x1..0x8 emerge in order one per cycle.
REQ-035 SHALL cover: out_ready_i=0, accept 0xA then 0xB -> occupancy_o=2, in_ready_o=0, out_data_o=0xA stable; raise out_ready_i -> 0xA then 0xB delivered, nothing lost (skid build); non-skid build stalls 0xB in upstream.
REQ-036 SHALL cover: in_data_i=0x5, sub_data_i=0x7, sub_i=1 at accept -> out_data_o=0x7; sub_i=1 with in_valid_i=0 -> occupancy_o unchanged.
REQ-037 SHALL cover: occupancy_o=2, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, occupancy_o=0, in_ready_o=1, flushed input never appears.
REQ-038 SHALL cover: rst_i driven low between clock edges with occupancy_o=2 -> outputs reach REQ-029 values before next edge; after release accept 0x3 -> out_data_o=0x3 one cycle later.
